// File: rtl/regfile_write_sequencer.sv
// Writeback front end for the register file: merges load-path and ALU-path
// requests into a small in-order queue and drains one write per clock.
module regfile_write_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       MemValid,
    output logic                       MemReady,
    input  logic [ADDR_WIDTH-1:0]      MemRW,
    input  logic [DATA_WIDTH-1:0]      MemBusW,
    input  logic                       AluValid,
    output logic                       AluReady,
    input  logic [ADDR_WIDTH-1:0]      AluRW,
    input  logic [DATA_WIDTH-1:0]      AluBusW,
    output logic                       RegWr,
    output logic [ADDR_WIDTH-1:0]      RW,
    output logic [DATA_WIDTH-1:0]      BusW,
    input  logic [ADDR_WIDTH-1:0]      RA,
    output logic                       FwdHit,
    output logic [DATA_WIDTH-1:0]      FwdData,
    output logic [(2**ADDR_WIDTH)-1:0] Pending,
    output logic                       Empty,
    output logic                       Full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      free;
    logic [CNT_W-1:0]      alu_need;
    logic [ADDR_WIDTH-1:0] rw_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    logic mem_nz;
    logic alu_nz;
    logic mem_enq;
    logic alu_enq;
    logic pop;

    assign mem_nz   = (MemRW != '0);
    assign alu_nz   = (AluRW != '0);
    assign free     = CNT_W'(DEPTH) - count;

    // Alu must leave room for a Mem request that claims a slot in the same cycle;
    // neither side credits the pop happening this cycle, so Ready has no path from the head.
    assign alu_need = CNT_W'(1) + CNT_W'(MemValid & mem_nz);
    assign MemReady = !mem_nz || (free >= CNT_W'(1));
    assign AluReady = !alu_nz || (free >= alu_need);

    // Writes to register 0 are handshaken but never stored.
    assign mem_enq  = MemValid && MemReady && mem_nz;
    assign alu_enq  = AluValid && AluReady && alu_nz;

    assign Empty    = (count == '0);
    assign Full     = (count == CNT_W'(DEPTH));
    assign pop      = !Empty;

    assign RegWr    = !Empty;
    assign RW       = Empty ? '0 : rw_q[rd_ptr];
    assign BusW     = Empty ? '0 : data_q[rd_ptr];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(mem_enq) + PTR_W'(alu_enq);
            count  <= count + CNT_W'(mem_enq) + CNT_W'(alu_enq) - CNT_W'(pop);
        end
    end

    // Mem takes the older slot when both enqueue together.
    always_ff @(posedge Clk) begin
        if (mem_enq) begin
            rw_q[wr_ptr]   <= MemRW;
            data_q[wr_ptr] <= MemBusW;
        end
        if (alu_enq) begin
            rw_q[wr_ptr + PTR_W'(mem_enq)]   <= AluRW;
            data_q[wr_ptr + PTR_W'(mem_enq)] <= AluBusW;
        end
    end

    // Walk entries oldest to youngest so the last match is the youngest.
    always_comb begin
        Pending = '0;
        FwdHit  = 1'b0;
        FwdData = '0;
        for (int a = 0; a < DEPTH; a++) begin
            if (CNT_W'(a) < count) begin
                Pending[rw_q[rd_ptr + PTR_W'(a)]] = 1'b1;
                if ((RA != '0) && (rw_q[rd_ptr + PTR_W'(a)] == RA)) begin
                    FwdHit  = 1'b1;
                    FwdData = data_q[rd_ptr + PTR_W'(a)];
                end
            end
        end
    end

endmodule

// File: doc/regfile_write_sequencer.md
Name: regfile_write_sequencer

Overview:
- Writer-side front end for the 32x32 register file write port (BusW/RW/RegWr).
- Accepts writeback requests from two producers, the load path (Mem) and the ALU path (Alu), through valid/ready handshakes.
- Orders the requests in a small FIFO and drains one write per clock into the register file.
- Exposes a per-register pending mask and a forwarding lookup so the decode stage can read queued values before they land in the file.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers)
DEPTH, 4, write queue entries (power of two, >=2)

Ports:
Clk  input  1  clock, all state updates on posedge
Rst_n  input  1  asynchronous active-low reset
MemValid  input  1  load-path write request valid
MemReady  output  1  load-path request accepted this cycle when MemValid=1
MemRW  input  ADDR_WIDTH  load-path destination register
MemBusW  input  DATA_WIDTH  load-path write data
AluValid  input  1  ALU-path write request valid
AluReady  output  1  ALU-path request accepted this cycle when AluValid=1
AluRW  input  ADDR_WIDTH  ALU-path destination register
AluBusW  input  DATA_WIDTH  ALU-path write data
RegWr  output  1  register file write enable
RW  output  ADDR_WIDTH  register file write address
BusW  output  DATA_WIDTH  register file write data
RA  input  ADDR_WIDTH  forwarding lookup address
FwdHit  output  1  a queued write targets RA
FwdData  output  DATA_WIDTH  data of the youngest queued write to RA
Pending  output  2**ADDR_WIDTH  bit i set if any queued entry targets register i
Empty  output  1  queue holds no entries
Full  output  1  queue holds DEPTH entries

Behaviour:
- Reset (Rst_n=0, asynchronous): clear read/write pointers and count.
  - While in reset: RegWr=0, RW=0, BusW=0, Pending=0, FwdHit=0, FwdData=0, Empty=1, Full=0.
  - Reset asserted mid-operation discards all queued writes; none reach the file.
- Occupancy: count = valid entries; free = DEPTH-count. Ready never accounts for a same-cycle pop (conservative, no comb loop).
- Ready rules:
  - MemReady = (MemRW==0) | (free>=1).
  - AluReady = (AluRW==0) | (free >= 1 + (MemValid & MemRW!=0)).
- Accept = Valid & Ready on a posedge.
  - Requests with RW=0 are accepted and dropped (never enqueued, no Pending change).
- Enqueue ordering: when both are accepted in the same cycle, the Mem entry is enqueued first (older), then the Alu entry; up to 2 enqueues per cycle.
- Drain:
  - Head is presented combinationally: RegWr=!Empty, RW/BusW = head fields when non-empty, else 0.
  - On each posedge with !Empty, the head pops; the register file captures it on that same edge.
- Latency: a request accepted at edge N is at the head no earlier than cycle N..N+1 and is written at edge N+1 if the queue was empty before N.
- Count update: count_next = count + enq(0..2) - pop(0/1), computed in the same cycle.
- Pending: combinational OR over valid entries of the decoded RW.
- Forwarding: combinational.
  - FwdHit=1 if RA!=0 and any valid entry has RW==RA.
  - FwdData = data of the youngest such entry, else 0.
  - An entry popping this cycle still counts as a hit during that cycle.
- Flags: Full=(count==DEPTH), Empty=(count==0). Pointers wrap modulo DEPTH.

Test Plan:
- Single write: AluValid=1, AluRW=5, AluBusW=0xDEADBEEF for one cycle → next cycle RegWr=1, RW=5, BusW=0xDEADBEEF, Pending[5]=1, FwdHit=1 for RA=5; one cycle later RegWr=0, Pending=0.
- Same-cycle ordering, with queue empty and both requests in one cycle: Mem RW=3 data=0x11; Alu RW=3 data=0x22.
  - Both Ready=1.
  - Writes drain as (3,0x11) then (3,0x22).
  - FwdData(RA=3)=0x22 in both drain cycles.
- Zero register: AluValid=1, AluRW=0, AluBusW=0xFFFFFFFF → AluReady=1, RegWr stays 0, Pending unchanged, FwdHit(RA=0)=0.
- Backpressure: both valid every cycle, nonzero RWs → count goes 0→2→3 and holds at 3; AluReady=0 and MemReady=1 at count 3; the RW sequence on the write port preserves Mem-before-Alu order.
- Reset mid-operation: queue 3 entries, drop Rst_n between edges → RegWr, Pending, FwdHit go to 0 immediately without a clock; after release Empty=1 and no stale write is issued.
- Youngest-forward: enqueue (7,0xA), (9,0xB), (7,0xC) → FwdData(RA=7)=0xC; Pending[7]=Pending[9]=1; after all three drain, Pending=0.
